// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory model that sits on the far side of a hart's data
// port. It takes one load or store at a time over a ready/valid handshake and
// returns a one-cycle response LATENCY cycles after the accept edge. It also
// handles the byte-lane work: sub-word store data and byte enables are shifted
// into place by the address offset, and load bytes are returned right-justified
// and zero-extended.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_dmem_addr    byte address (word index = addr[31:2])
//   i_dmem_ren     load request
//   i_dmem_wen     store request
//   i_dmem_wdata   right-justified store data
//   i_dmem_mask    size code: 0001 byte, 0011 half, 1111 word (unshifted)
//   o_dmem_ready   idle; a request present now is accepted at this edge
//   o_dmem_valid   one-cycle response pulse (loads and stores)
//   o_dmem_rdata   load data, zero for stores and errors; held until next commit
//   o_dmem_err     error flag, qualified by o_dmem_valid
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Expand a 4-bit byte mask into a 32-bit bit mask.
    function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{m[i]}};
        end
        return bits;
    endfunction

    // Decode every illegal-request condition for a (latched) request.
    function automatic logic req_error(input logic [31:0] addr,
                                       input logic        ren,
                                       input logic        wen,
                                       input logic [3:0]  mask);
        logic e;
        e = 1'b0;
        if (ren && wen) e = 1'b1;
        if ((mask != 4'b0001) && (mask != 4'b0011) && (mask != 4'b1111)) e = 1'b1;
        if ((mask == 4'b0011) && addr[0]) e = 1'b1;
        if ((mask == 4'b1111) && (addr[1:0] != 2'b00)) e = 1'b1;
        if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) e = 1'b1;
        return e;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         mask_q, mask_d;
    logic               ren_q, ren_d;
    logic               wen_q, wen_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept_s;
    logic               commit_s;
    logic [31:0]        c_addr_s;
    logic [31:0]        c_wdata_s;
    logic [3:0]         c_mask_s;
    logic               c_ren_s;
    logic               c_wen_s;
    logic               c_err_s;
    logic [IDX_W-1:0]   c_idx_s;
    logic [31:0]        rd_word_s;
    logic [3:0]         be_s;
    logic [31:0]        wdata_sh_s;
    logic               wr_s;

    // Next-state, request latch, commit datapath and response outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;

        accept_s = (state_q == ST_IDLE) && (i_dmem_ren || i_dmem_wen) && !i_rst;

        // With LATENCY == 1 the commit edge is the accept edge, so the request
        // is taken straight from the inputs while idle.
        if (state_q == ST_IDLE) begin
            c_addr_s  = i_dmem_addr;
            c_wdata_s = i_dmem_wdata;
            c_mask_s  = i_dmem_mask;
            c_ren_s   = i_dmem_ren;
            c_wen_s   = i_dmem_wen;
        end else begin
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
            c_mask_s  = mask_q;
            c_ren_s   = ren_q;
            c_wen_s   = wen_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d  = i_dmem_addr;
                    wdata_d = i_dmem_wdata;
                    mask_d  = i_dmem_mask;
                    ren_d   = i_dmem_ren;
                    wen_d   = i_dmem_wen;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        c_err_s    = req_error(c_addr_s, c_ren_s, c_wen_s, c_mask_s);
        c_idx_s    = c_addr_s[IDX_W+1:2];
        rd_word_s  = mem[c_idx_s];
        be_s       = c_mask_s << c_addr_s[1:0];
        wdata_sh_s = c_wdata_s << {c_addr_s[1:0], 3'b000};

        // Entering RESP (from IDLE or WAIT) is the commit edge.
        commit_s = (state_d == ST_RESP) && (state_q != ST_RESP) && !i_rst;
        wr_s     = commit_s && c_wen_s && !c_err_s;

        if (commit_s) begin
            valid_d = 1'b1;
            err_d   = c_err_s;
            if (c_ren_s && !c_err_s) begin
                rdata_d = (rd_word_s >> {c_addr_s[1:0], 3'b000}) & mask_to_bits(c_mask_s);
            end else begin
                rdata_d = 32'h0000_0000;
            end
        end else begin
            valid_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            mask_q  <= 4'b0000;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Byte-enabled array write; contents survive reset.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_s && be_s[b]) begin
                mem[c_idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
            end
        end
    end

    assign o_dmem_ready = (state_q == ST_IDLE);
    assign o_dmem_valid = valid_q;
    assign o_dmem_err   = err_q;
    assign o_dmem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for data-path,
// error and reset checks, and a LATENCY=1 instance for back-to-back handshake.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    logic [31:0] addr2, wdata2, rdata2;
    logic        ren2, wen2, ready2, valid2, err2;
    logic [3:0]  mask2;

    logic [31:0] addr1, wdata1, rdata1;
    logic        ren1, wen1, ready1, valid1, err1;
    logic [3:0]  mask1;

    int n_vec;
    int n_err;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .i_clk(clk), .i_rst(rst),
        .i_dmem_addr(addr2), .i_dmem_ren(ren2), .i_dmem_wen(wen2),
        .i_dmem_wdata(wdata2), .i_dmem_mask(mask2),
        .o_dmem_ready(ready2), .o_dmem_valid(valid2),
        .o_dmem_rdata(rdata2), .o_dmem_err(err2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
        .i_clk(clk), .i_rst(rst),
        .i_dmem_addr(addr1), .i_dmem_ren(ren1), .i_dmem_wen(wen1),
        .i_dmem_wdata(wdata1), .i_dmem_mask(mask1),
        .o_dmem_ready(ready1), .o_dmem_valid(valid1),
        .o_dmem_rdata(rdata1), .o_dmem_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [3:0] m);
        addr2 = a; ren2 = r; wen2 = w; wdata2 = d; mask2 = m;
    endtask

    task automatic idle2();
        drive2(32'h0, 1'b0, 1'b0, 32'h0, 4'b0000);
    endtask

    task automatic drive1(input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [3:0] m);
        addr1 = a; ren1 = r; wen1 = w; wdata1 = d; mask1 = m;
    endtask

    // One full LATENCY=2 transaction, starting in an idle cycle (cycle 0).
    task automatic xact2(input string tag, input logic [31:0] a, input logic r,
                         input logic w, input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp_rdata, input logic exp_err);
        drive2(a, r, w, d, m);
        step();
        idle2();
        chk({tag, ".c1_ready"}, {31'b0, ready2}, 32'd0);
        chk({tag, ".c1_valid"}, {31'b0, valid2}, 32'd0);
        step();
        chk({tag, ".c2_valid"}, {31'b0, valid2}, 32'd1);
        chk({tag, ".c2_ready"}, {31'b0, ready2}, 32'd0);
        chk({tag, ".err"},      {31'b0, err2},   {31'b0, exp_err});
        chk({tag, ".rdata"},    rdata2,          exp_rdata);
        step();
        chk({tag, ".c3_valid"}, {31'b0, valid2}, 32'd0);
        chk({tag, ".c3_ready"}, {31'b0, ready2}, 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle2();
        drive1(32'h0, 1'b0, 1'b0, 32'h0, 4'b0000);
        rst = 1'b1;
        step();
        step();
        chk("rst.ready", {31'b0, ready2}, 32'd1);
        chk("rst.valid", {31'b0, valid2}, 32'd0);
        chk("rst.err",   {31'b0, err2},   32'd0);
        chk("rst.rdata", rdata2,          32'd0);
        chk("rst1.ready", {31'b0, ready1}, 32'd1);
        rst = 1'b0;
        step();

        // Word round trip and sub-word accesses
        xact2("sw10",  32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        xact2("lw10",  32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b0);
        xact2("sb13",  32'h13, 1'b0, 1'b1, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        xact2("lw10b", 32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hAAADBEEF, 1'b0);
        xact2("lb13",  32'h13, 1'b1, 1'b0, 32'h0,        4'b0001, 32'h000000AA, 1'b0);
        xact2("lh12",  32'h12, 1'b1, 1'b0, 32'h0,        4'b0011, 32'h0000AAAD, 1'b0);
        xact2("lb10",  32'h10, 1'b1, 1'b0, 32'h0,        4'b0001, 32'h000000EF, 1'b0);

        // Misaligned accesses
        xact2("lw11",  32'h11, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h0, 1'b1);
        xact2("sh13",  32'h13, 1'b0, 1'b1, 32'h00005555, 4'b0011, 32'h0, 1'b1);
        xact2("lw10c", 32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hAAADBEEF, 1'b0);

        // Illegal requests
        xact2("rw",    32'h10, 1'b1, 1'b1, 32'h12345678, 4'b1111, 32'h0, 1'b1);
        xact2("lw10d", 32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hAAADBEEF, 1'b0);
        xact2("m0101", 32'h10, 1'b0, 1'b1, 32'h00000000, 4'b0101, 32'h0, 1'b1);
        xact2("lw10e", 32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hAAADBEEF, 1'b0);
        xact2("sw0",   32'h0,  1'b0, 1'b1, 32'h01020304, 4'b1111, 32'h0, 1'b0);
        xact2("sw1000",32'h1000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1);
        xact2("lw1000",32'h1000, 1'b1, 1'b0, 32'h0,        4'b1111, 32'h0, 1'b1);
        xact2("lw0",   32'h0,  1'b1, 1'b0, 32'h0,        4'b1111, 32'h01020304, 1'b0);

        // Half-word store into the upper lane
        xact2("sh12",  32'h12, 1'b0, 1'b1, 32'h0000BEEF, 4'b0011, 32'h0, 1'b0);
        xact2("lw10f", 32'h10, 1'b1, 1'b0, 32'h0,        4'b1111, 32'hBEEFBEEF, 1'b0);

        // Handshake: second request held from cycle 1, accepted at end of cycle 3
        drive2(32'h10, 1'b1, 1'b0, 32'h0, 4'b1111);
        step();
        drive2(32'h11, 1'b1, 1'b0, 32'h0, 4'b0001);
        chk("hs.c1_ready", {31'b0, ready2}, 32'd0);
        step();
        chk("hs.c2_valid", {31'b0, valid2}, 32'd1);
        chk("hs.c2_rdata", rdata2, 32'hBEEFBEEF);
        step();
        chk("hs.c3_ready", {31'b0, ready2}, 32'd1);
        chk("hs.c3_valid", {31'b0, valid2}, 32'd0);
        step();
        idle2();
        chk("hs.c4_ready", {31'b0, ready2}, 32'd0);
        chk("hs.c4_valid", {31'b0, valid2}, 32'd0);
        step();
        chk("hs.c5_valid", {31'b0, valid2}, 32'd1);
        chk("hs.c5_rdata", rdata2, 32'h000000BE);
        step();
        chk("hs.c6_ready", {31'b0, ready2}, 32'd1);

        // Reset mid-operation discards the pending store
        xact2("sw20",  32'h20, 1'b0, 1'b1, 32'h11111111, 4'b1111, 32'h0, 1'b0);
        drive2(32'h20, 1'b0, 1'b1, 32'h22222222, 4'b1111);
        step();
        idle2();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid.c2_valid", {31'b0, valid2}, 32'd0);
        chk("rmid.c2_ready", {31'b0, ready2}, 32'd1);
        step();
        chk("rmid.c3_valid", {31'b0, valid2}, 32'd0);
        xact2("lw20",  32'h20, 1'b1, 1'b0, 32'h0, 4'b1111, 32'h11111111, 1'b0);

        // A request coinciding with reset is not accepted
        rst = 1'b1;
        drive2(32'h20, 1'b1, 1'b0, 32'h0, 4'b1111);
        step();
        rst = 1'b0;
        idle2();
        chk("rstreq.ready", {31'b0, ready2}, 32'd1);
        step();
        chk("rstreq.valid", {31'b0, valid2}, 32'd0);
        chk("rstreq.ready2", {31'b0, ready2}, 32'd1);

        // LATENCY=1: valid in cycle 1, accepts every two cycles
        drive1(32'h40, 1'b0, 1'b1, 32'hCAFEF00D, 4'b1111);
        step();
        drive1(32'h40, 1'b1, 1'b0, 32'h0, 4'b1111);
        chk("l1.c1_valid", {31'b0, valid1}, 32'd1);
        chk("l1.c1_ready", {31'b0, ready1}, 32'd0);
        chk("l1.c1_rdata", rdata1, 32'h0);
        step();
        chk("l1.c2_ready", {31'b0, ready1}, 32'd1);
        chk("l1.c2_valid", {31'b0, valid1}, 32'd0);
        step();
        drive1(32'h41, 1'b1, 1'b0, 32'h0, 4'b0001);
        chk("l1.c3_valid", {31'b0, valid1}, 32'd1);
        chk("l1.c3_rdata", rdata1, 32'hCAFEF00D);
        step();
        chk("l1.c4_ready", {31'b0, ready1}, 32'd1);
        step();
        drive1(32'h0, 1'b0, 1'b0, 32'h0, 4'b0000);
        chk("l1.c5_valid", {31'b0, valid1}, 32'd1);
        chk("l1.c5_rdata", rdata1, 32'h000000F0);
        chk("l1.c5_err",   {31'b0, err1},   32'd0);
        step();
        chk("l1.c6_valid", {31'b0, valid1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
